hi_lo_multiply_divide_unit: RTL and testbench
=============================================

HI_LO_MULTIPLY_DIVIDE_UNIT -- requirements
Module: hi_lo_multiply_divide_unit

Interface
REQ-001 SHALL have port: clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-003 SHALL have port: start_execute  input  1  begins a multiply/divide using the operands and operation presented this cycle.
REQ-004 SHALL have port: operation_execute  input  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-005 SHALL have port: operand_a_execute  input  32  rs value (multiplicand/dividend).
REQ-006 SHALL have port: operand_b_execute  input  32  rt value (multiplier/divisor).
REQ-007 SHALL have port: hi_write_execute  input  1  MTHI: load operand_a_execute into HI.
REQ-008 SHALL have port: lo_write_execute  input  1  MTLO: load operand_a_execute into LO.
REQ-009 SHALL have port: hi_lo_access_decode  input  1  the instruction in decode reads or writes HI/LO (MFHI, MFLO, MTHI, MTLO, MULT*, DIV*).
REQ-010 SHALL have port: hi_output  output  32  current HI register.
REQ-011 SHALL have port: lo_output  output  32  current LO register.
REQ-012 SHALL have port: busy  output  1  an operation is in progress.
REQ-013 SHALL have port: stall_request  output  1  stall request to the hazard unit, combining into stall_fetch/stall_decode/flush_execute_register.
REQ-014 SHALL have port: done  output  1  one-cycle pulse: HI/LO just updated with a result.

Function
REQ-015 SHALL implement states IDLE, MULTIPLY, DIVIDE, FINISH, plus a 5-bit iteration counter.
REQ-016 In IDLE with start_execute=1, SHALL latch operands, operation and operand signs, and enter MULTIPLY (op 0x) or DIVIDE (op 1x) with counter=0; this edge is "acceptance".
REQ-017 Signed ops (MULT, DIV) SHALL operate on operand magnitudes and apply sign correction in FINISH; unsigned ops use operands unmodified.
REQ-018 MULTIPLY SHALL perform one radix-2 shift-add step per cycle for 32 cycles, forming a 64-bit product.
REQ-019 DIVIDE SHALL perform one restoring-division step per cycle for 32 cycles, forming a 32-bit quotient and remainder.
REQ-020 After the 32nd step (counter=31), SHALL enter FINISH; on the following edge write HI/LO and return to IDLE.
REQ-021 Multiply result: HI = product[63:32], LO = product[31:0]; for MULT the product is negated when operand signs differ.
REQ-022 Divide result: LO = quotient, HI = remainder; for DIV, quotient negated when signs differ, remainder takes dividend sign.
REQ-023 Divide by zero SHALL still take full latency and yield LO=0xFFFFFFFF, HI=dividend (as latched, unsigned bit pattern).
REQ-024 DIV 0x80000000 / 0xFFFFFFFF SHALL yield LO=0x80000000, HI=0x00000000 (32-bit wrap, no trap).
REQ-025 busy SHALL be 1 exactly in the 33 cycles after acceptance (MULTIPLY/DIVIDE/FINISH), 0 otherwise.
REQ-026 done SHALL be 1 for exactly the cycle after the HI/LO result write; HI/LO show the new result that cycle.
REQ-027 stall_request SHALL equal busy AND hi_lo_access_decode (combinational).
REQ-028 start_execute while busy SHALL be ignored; the running operation continues unchanged.
REQ-029 hi_write_execute/lo_write_execute SHALL update HI/LO on the next edge only when IDLE and start_execute=0; both may apply in the same cycle.
REQ-030 start_execute SHALL take priority over simultaneous hi_write_execute/lo_write_execute; the writes are dropped.
REQ-031 HI/LO SHALL be unchanged during an operation until the FINISH write.

Reset
REQ-032 reset=1 SHALL force IDLE, counter=0, HI=0, LO=0, busy=0, done=0, stall_request=0 (since busy=0), at any time, including mid-operation.
REQ-033 reset SHALL override start_execute and HI/LO writes presented in the same cycle; the aborted operation never writes HI/LO.

Verification
REQ-034 MULTU 0xFFFFFFFF x 0x00000002 -> busy 33 cycles, then HI=0x00000001, LO=0xFFFFFFFE, done one cycle.
REQ-035 MULT 0xFFFFFFFD (-3) x 0x00000007 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB.
REQ-036 DIV 0xFFFFFFF9 (-7) / 0x00000002 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 7/0 -> LO=0xFFFFFFFF, HI=0x00000007.
REQ-037 hi_lo_access_decode=1 during busy -> stall_request=1 every busy cycle, 0 in the done cycle; second start mid-operation -> result matches first operation only.
REQ-038 MTHI 0x12345678 and MTLO 0x9ABCDEF0 together when idle -> HI/LO take values next cycle; same with start_execute=1 -> writes dropped, operation result written.
REQ-039 reset asserted at cycle 10 of a DIVU -> next cycle HI=LO=0, busy=0, done never pulses.

Source files
------------

// File: rtl/hi_lo_multiply_divide_unit.sv
// HI/LO multiply/divide unit: 32-cycle radix-2 multiply and restoring
// divide writing a 64-bit result into the HI/LO register pair.
module hi_lo_multiply_divide_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_execute,
    input  logic [1:0]  operation_execute,
    input  logic [31:0] operand_a_execute,
    input  logic [31:0] operand_b_execute,
    input  logic        hi_write_execute,
    input  logic        lo_write_execute,
    input  logic        hi_lo_access_decode,
    output logic [31:0] hi_output,
    output logic [31:0] lo_output,
    output logic        busy,
    output logic        stall_request,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE,
        MULTIPLY,
        DIVIDE,
        FINISH
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] opnd_q, opnd_d;
    logic [31:0] dvd_q, dvd_d;
    logic        is_div_q, is_div_d;
    logic        neg_q, neg_d;
    logic        rneg_q, rneg_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        done_q, done_d;

    logic        op_signed;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic [33:0] div_trial;
    logic [63:0] div_next;
    logic [63:0] prod_fix;
    logic [31:0] quot_fix;
    logic [31:0] rem_fix;

    assign op_signed = ~operation_execute[0];
    assign a_mag = (op_signed && operand_a_execute[31]) ?
                   -operand_a_execute : operand_a_execute;
    assign b_mag = (op_signed && operand_b_execute[31]) ?
                   -operand_b_execute : operand_b_execute;

    // acc holds {partial product, remaining multiplier bits}
    assign mul_sum  = {1'b0, acc_q[63:32]} +
                      (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
    assign mul_next = {mul_sum, acc_q[31:1]};

    // acc holds {remainder, dividend bits shifting into quotient}
    assign div_trial = {1'b0, acc_q[63:32], acc_q[31]} - {2'b00, opnd_q};
    assign div_next  = div_trial[33] ?
                       {acc_q[62:0], 1'b0} :
                       {div_trial[31:0], acc_q[30:0], 1'b1};

    assign prod_fix = neg_q  ? -acc_q         : acc_q;
    assign quot_fix = neg_q  ? -acc_q[31:0]   : acc_q[31:0];
    assign rem_fix  = rneg_q ? -acc_q[63:32]  : acc_q[63:32];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        dvd_d    = dvd_q;
        is_div_d = is_div_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_execute) begin
                    cnt_d    = 5'd0;
                    is_div_d = operation_execute[1];
                    dvd_d    = operand_a_execute;
                    rneg_d   = op_signed & operand_a_execute[31];
                    neg_d    = op_signed &
                               (operand_a_execute[31] ^ operand_b_execute[31]);
                    if (operation_execute[1]) begin
                        acc_d   = {32'd0, a_mag};
                        opnd_d  = b_mag;
                        state_d = DIVIDE;
                    end else begin
                        acc_d   = {32'd0, b_mag};
                        opnd_d  = a_mag;
                        state_d = MULTIPLY;
                    end
                end else begin
                    if (hi_write_execute) hi_d = operand_a_execute;
                    if (lo_write_execute) lo_d = operand_a_execute;
                end
            end
            MULTIPLY: begin
                acc_d = mul_next;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) state_d = FINISH;
            end
            DIVIDE: begin
                acc_d = div_next;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) state_d = FINISH;
            end
            FINISH: begin
                state_d = IDLE;
                done_d  = 1'b1;
                if (!is_div_q) begin
                    hi_d = prod_fix[63:32];
                    lo_d = prod_fix[31:0];
                end else if (opnd_q == 32'd0) begin
                    // Divide by zero reports the raw dividend, no sign fixup
                    hi_d = dvd_q;
                    lo_d = 32'hFFFF_FFFF;
                end else begin
                    hi_d = rem_fix;
                    lo_d = quot_fix;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= 5'd0;
            acc_q    <= 64'd0;
            opnd_q   <= 32'd0;
            dvd_q    <= 32'd0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            dvd_q    <= dvd_d;
            is_div_q <= is_div_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    assign hi_output     = hi_q;
    assign lo_output     = lo_q;
    assign busy          = (state_q != IDLE);
    assign stall_request = busy & hi_lo_access_decode;
    assign done          = done_q;

endmodule

// File: tb/tb_hi_lo_multiply_divide_unit.sv
// Directed bench for the HI/LO multiply/divide unit.
module tb_hi_lo_multiply_divide_unit;

    logic        clk;
    logic        reset;
    logic        start_execute;
    logic [1:0]  operation_execute;
    logic [31:0] operand_a_execute;
    logic [31:0] operand_b_execute;
    logic        hi_write_execute;
    logic        lo_write_execute;
    logic        hi_lo_access_decode;
    logic [31:0] hi_output;
    logic [31:0] lo_output;
    logic        busy;
    logic        stall_request;
    logic        done;

    int vectors = 0;
    int errors  = 0;

    hi_lo_multiply_divide_unit dut (
        .clk                 (clk),
        .reset               (reset),
        .start_execute       (start_execute),
        .operation_execute   (operation_execute),
        .operand_a_execute   (operand_a_execute),
        .operand_b_execute   (operand_b_execute),
        .hi_write_execute    (hi_write_execute),
        .lo_write_execute    (lo_write_execute),
        .hi_lo_access_decode (hi_lo_access_decode),
        .hi_output           (hi_output),
        .lo_output           (lo_output),
        .busy                (busy),
        .stall_request       (stall_request),
        .done                (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Starts an op at a negedge, then samples each following negedge until
    // busy drops. inj >= 0 injects a second start (or reset) at that busy cycle.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic acc,
                          input logic wr, input int inj, input logic inj_rst,
                          output int nb, output int nstall, output int nchg);
        logic [31:0] hi0, lo0;
        nb = 0;
        nstall = 0;
        nchg = 0;
        @(negedge clk);
        hi0 = hi_output;
        lo0 = lo_output;
        start_execute = 1'b1;
        operation_execute = op;
        operand_a_execute = a;
        operand_b_execute = b;
        hi_lo_access_decode = acc;
        hi_write_execute = wr;
        lo_write_execute = wr;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            start_execute = 1'b0;
            hi_write_execute = 1'b0;
            lo_write_execute = 1'b0;
            reset = 1'b0;
            if (!busy) break;
            nb++;
            if (stall_request) nstall++;
            if (hi_output !== hi0 || lo_output !== lo0) nchg++;
            if (i == inj) begin
                if (inj_rst) begin
                    reset = 1'b1;
                end else begin
                    start_execute = 1'b1;
                    operation_execute = 2'b11;
                    operand_a_execute = 32'd100;
                    operand_b_execute = 32'd7;
                    hi_write_execute = 1'b1;
                end
            end
        end
        hi_lo_access_decode = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        reset = 1'b1;
        start_execute = 1'b1;
        hi_write_execute = 1'b1;
        lo_write_execute = 1'b1;
        operand_a_execute = 32'hAAAA_5555;
        hi_lo_access_decode = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if (hi_output !== 32'd0) begin
            errors++;
            $display("FAIL reset_hi got %h exp 00000000", hi_output);
        end
        vectors++;
        if (lo_output !== 32'd0) begin
            errors++;
            $display("FAIL reset_lo got %h exp 00000000", lo_output);
        end
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || stall_request !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags got busy=%b done=%b stall=%b exp 0/0/0",
                     busy, done, stall_request);
        end
        reset = 1'b0;
        start_execute = 1'b0;
        hi_write_execute = 1'b0;
        lo_write_execute = 1'b0;
        hi_lo_access_decode = 1'b0;
    endtask

    task automatic check_result(input string name, input logic [31:0] ehi,
                                input logic [31:0] elo, input int nb,
                                input int nchg);
        vectors++;
        if (nb !== 33) begin
            errors++;
            $display("FAIL %s_busy_cycles got %0d exp 33", name, nb);
        end
        vectors++;
        if (nchg !== 0) begin
            errors++;
            $display("FAIL %s_hilo_stable got %0d changes exp 0", name, nchg);
        end
        vectors++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL %s_done got %b exp 1", name, done);
        end
        vectors++;
        if (hi_output !== ehi || lo_output !== elo) begin
            errors++;
            $display("FAIL %s_result got hi=%h lo=%h exp hi=%h lo=%h",
                     name, hi_output, lo_output, ehi, elo);
        end
        @(negedge clk);
        vectors++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL %s_done_pulse got %b exp 0", name, done);
        end
    endtask

    task automatic test_multu;
        int nb, ns, nc;
        run_op(2'b01, 32'hFFFF_FFFF, 32'h2, 1'b0, 1'b0, -1, 1'b0, nb, ns, nc);
        check_result("multu", 32'h1, 32'hFFFF_FFFE, nb, nc);
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, -1, 1'b0,
               nb, ns, nc);
        check_result("multu_max", 32'hFFFF_FFFE, 32'h1, nb, nc);
    endtask

    task automatic test_mult;
        int nb, ns, nc;
        run_op(2'b00, 32'hFFFF_FFFD, 32'h7, 1'b0, 1'b0, -1, 1'b0, nb, ns, nc);
        check_result("mult_neg", 32'hFFFF_FFFF, 32'hFFFF_FFEB, nb, nc);
        run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, -1, 1'b0,
               nb, ns, nc);
        check_result("mult_min", 32'h4000_0000, 32'h0, nb, nc);
    endtask

    task automatic test_div;
        int nb, ns, nc;
        run_op(2'b10, 32'hFFFF_FFF9, 32'h2, 1'b0, 1'b0, -1, 1'b0, nb, ns, nc);
        check_result("div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD, nb, nc);
        run_op(2'b10, 32'h7, 32'hFFFF_FFFE, 1'b0, 1'b0, -1, 1'b0, nb, ns, nc);
        check_result("div_rem_sign", 32'h1, 32'hFFFF_FFFD, nb, nc);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, -1, 1'b0,
               nb, ns, nc);
        check_result("div_overflow", 32'h0, 32'h8000_0000, nb, nc);
        run_op(2'b11, 32'h7, 32'h0, 1'b0, 1'b0, -1, 1'b0, nb, ns, nc);
        check_result("divu_zero", 32'h7, 32'hFFFF_FFFF, nb, nc);
        run_op(2'b10, 32'hFFFF_FFF0, 32'h0, 1'b0, 1'b0, -1, 1'b0, nb, ns, nc);
        check_result("div_zero", 32'hFFFF_FFF0, 32'hFFFF_FFFF, nb, nc);
    endtask

    task automatic test_stall_and_ignore;
        int nb, ns, nc;
        run_op(2'b01, 32'd3, 32'd5, 1'b1, 1'b0, 4, 1'b0, nb, ns, nc);
        vectors++;
        if (ns !== 33) begin
            errors++;
            $display("FAIL stall_cycles got %0d exp 33", ns);
        end
        vectors++;
        if (stall_request !== 1'b0) begin
            errors++;
            $display("FAIL stall_done_cycle got %b exp 0", stall_request);
        end
        check_result("ignore_start", 32'h0, 32'd15, nb, nc);
    endtask

    task automatic test_mthi_mtlo;
        @(negedge clk);
        hi_write_execute = 1'b1;
        operand_a_execute = 32'h1234_5678;
        @(negedge clk);
        hi_write_execute = 1'b0;
        lo_write_execute = 1'b1;
        operand_a_execute = 32'h9ABC_DEF0;
        vectors++;
        if (hi_output !== 32'h1234_5678) begin
            errors++;
            $display("FAIL mthi got %h exp 12345678", hi_output);
        end
        @(negedge clk);
        hi_write_execute = 1'b1;
        lo_write_execute = 1'b1;
        operand_a_execute = 32'hDEAD_BEEF;
        vectors++;
        if (lo_output !== 32'h9ABC_DEF0 || hi_output !== 32'h1234_5678) begin
            errors++;
            $display("FAIL mtlo got hi=%h lo=%h exp hi=12345678 lo=9abcdef0",
                     hi_output, lo_output);
        end
        @(negedge clk);
        hi_write_execute = 1'b0;
        lo_write_execute = 1'b0;
        vectors++;
        if (hi_output !== 32'hDEAD_BEEF || lo_output !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL mthi_mtlo_both got hi=%h lo=%h exp deadbeef",
                     hi_output, lo_output);
        end
    endtask

    task automatic test_start_priority;
        int nb, ns, nc;
        run_op(2'b01, 32'd6, 32'd7, 1'b0, 1'b1, -1, 1'b0, nb, ns, nc);
        check_result("start_priority", 32'h0, 32'h2A, nb, nc);
    endtask

    task automatic test_reset_mid;
        int nb, ns, nc, pulses;
        run_op(2'b11, 32'h1000, 32'd3, 1'b0, 1'b0, 9, 1'b1, nb, ns, nc);
        vectors++;
        if (nb !== 10) begin
            errors++;
            $display("FAIL reset_mid_busy_cycles got %0d exp 10", nb);
        end
        vectors++;
        if (hi_output !== 32'd0 || lo_output !== 32'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_state got hi=%h lo=%h busy=%b exp 0/0/0",
                     hi_output, lo_output, busy);
        end
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            if (done !== 1'b0) pulses++;
            @(negedge clk);
        end
        vectors++;
        if (pulses !== 0 || hi_output !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid_no_done got %0d pulses hi=%h exp 0",
                     pulses, hi_output);
        end
    endtask

    initial begin
        reset = 1'b1;
        start_execute = 1'b0;
        operation_execute = 2'b00;
        operand_a_execute = 32'd0;
        operand_b_execute = 32'd0;
        hi_write_execute = 1'b0;
        lo_write_execute = 1'b0;
        hi_lo_access_decode = 1'b0;
        test_reset;
        test_multu;
        test_mult;
        test_div;
        test_stall_and_ignore;
        test_mthi_mtlo;
        test_start_priority;
        test_mthi_mtlo;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
